// File: rtl/rv32_types_pkg.sv
// rv32_types: shared RV32 pipeline types used by the memory stage.
// Contents:
//   - instruction/buffer structs
//   - data-memory request layout
//   - memory-op enumeration and the MEM-stage FSM state type
//   - helpers: create_nop_ctrl, create_nop_buffer, is_misaligned, is_load
package rv32_types;

    typedef logic [31:0] rv32_word;

    localparam logic [6:0] OPCODE_INTEGER_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD        = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE       = 7'b0100011;

    // addi x0, x0, 0
    localparam rv32_word RV_NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        mem_op_t    mem_op;
        logic       register_wb;
        logic       invalid;
    } decoded_instr_t;

    typedef struct packed {
        rv32_word       instr;
        rv32_word       pc;
        decoded_instr_t decoded_instr;
        rv32_word       mem_addr;
        rv32_word       wb_result;
    } exec_mem_buffer_t;

    // The writeback buffer carries the same fields as the exec buffer.
    typedef exec_mem_buffer_t mem_wb_buffer_t;

    typedef struct packed {
        rv32_word addr;
        mem_op_t  op;
        rv32_word data;
    } memory_request_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT_RESP
    } mem_stage_state_t;

    function automatic decoded_instr_t create_nop_ctrl();
        decoded_instr_t c;
        c.opcode      = OPCODE_INTEGER_IMM;
        c.rd          = 5'd0;
        c.mem_op      = MEM_NOP;
        c.register_wb = 1'b0;
        c.invalid     = 1'b0;
        return c;
    endfunction

    function automatic exec_mem_buffer_t create_nop_buffer();
        exec_mem_buffer_t b;
        b.instr         = RV_NOP;
        b.pc            = '0;
        b.decoded_instr = create_nop_ctrl();
        b.mem_addr      = '0;
        b.wb_result     = '0;
        return b;
    endfunction

    function automatic logic is_misaligned(mem_op_t op, logic [1:0] offset);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return offset[0];
            MEM_LW, MEM_SW:          return offset != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: selects the addressed lane of an aligned load word and
// sign/zero extends it to 32 bits.
// Ports:
//   word   in   aligned 32-bit word returned by data memory
//   op     in   load operation (LB/LBU/LH/LHU/LW)
//   offset in   low address bits of the access
//   data   out  extracted, extended load result
module rv32_load_align
    import rv32_types::*;
(
    input  logic [31:0] word,
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    output rv32_word    data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word >> {offset, 3'b000});
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (op)
            // Size cast of a signed lane replicates its sign bit.
            MEM_LB:  data = 32'(lane_b);
            MEM_LH:  data = 32'(lane_h);
            MEM_LBU: data = {24'h0, lane_b};
            MEM_LHU: data = {16'h0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/rv32_mem_stage.sv
// rv32_mem_stage: RV32 memory stage. Issues loads/stores to data memory,
// stalls upstream while a request is unaccepted or a load response is
// outstanding, and registers the result into the writeback buffer.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   exec_mem_i          instruction from exec (held while stall_o=1)
//   stall_o             combinational upstream stall
//   dmem_req_o          request: addr, op, replicated store data
//   dmem_req_valid_o    request valid
//   dmem_req_ready_i    memory accepts request this cycle
//   dmem_resp_valid_i   load data valid
//   dmem_resp_data_i    aligned load word
//   mem_wb_o            registered writeback buffer
//   misaligned_o        registered one-cycle misalignment flag
module rv32_mem_stage
    import rv32_types::*;
#(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  exec_mem_buffer_t exec_mem_i,
    output logic             stall_o,
    output memory_request_t  dmem_req_o,
    output logic             dmem_req_valid_o,
    input  logic             dmem_req_ready_i,
    input  logic             dmem_resp_valid_i,
    input  logic [31:0]      dmem_resp_data_i,
    output mem_wb_buffer_t   mem_wb_o,
    output logic             misaligned_o
);

    function automatic rv32_word natural_addr(mem_op_t op, rv32_word a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return {a[31:1], 1'b0};
            MEM_LW, MEM_SW:          return {a[31:2], 2'b00};
            default:                 return a;
        endcase
    endfunction

    function automatic rv32_word store_lanes(mem_op_t op, rv32_word d);
        case (op)
            MEM_SB:  return {4{d[7:0]}};
            MEM_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    mem_stage_state_t state;
    mem_op_t          in_op;
    logic             is_mem;
    logic             trap;
    logic             issue;
    logic             accept;
    rv32_word         req_addr;
    mem_op_t          cap_op;
    logic [1:0]       cap_off;
    rv32_word         load_data;
    mem_wb_buffer_t   wb_next;

    assign in_op  = exec_mem_i.decoded_instr.mem_op;
    assign is_mem = (in_op != MEM_NOP) && !exec_mem_i.decoded_instr.invalid;
    assign trap   = (ALIGN_CHECK != 0) && is_mem &&
                    is_misaligned(in_op, exec_mem_i.mem_addr[1:0]);
    assign issue  = (state == MEM_IDLE) && is_mem && !trap;
    assign accept = issue && dmem_req_ready_i;

    assign req_addr = (ALIGN_CHECK != 0) ? exec_mem_i.mem_addr
                                         : natural_addr(in_op, exec_mem_i.mem_addr);

    assign dmem_req_o.addr  = req_addr;
    assign dmem_req_o.op    = in_op;
    assign dmem_req_o.data  = store_lanes(in_op, exec_mem_i.wb_result);
    // Gated by resetn so nothing is requested while reset is held.
    assign dmem_req_valid_o = issue && resetn;

    // A store frees the stage on acceptance; a load always waits a cycle.
    assign stall_o = (state == MEM_WAIT_RESP) ? !dmem_resp_valid_i
                                              : issue && (!dmem_req_ready_i || is_load(in_op));

    rv32_load_align u_load_align (
        .word   (dmem_resp_data_i),
        .op     (cap_op),
        .offset (cap_off),
        .data   (load_data)
    );

    always_comb begin
        wb_next = exec_mem_i;
        if (stall_o) begin
            wb_next = create_nop_buffer();
        end else if (state == MEM_WAIT_RESP) begin
            wb_next.wb_result = load_data;
        end else if (trap) begin
            wb_next.decoded_instr.invalid     = 1'b1;
            wb_next.decoded_instr.register_wb = 1'b0;
        end
    end

    // Load capture: lane selection for the response cycle
    always_ff @(posedge clk) begin
        if (accept && is_load(in_op)) begin
            cap_op  <= in_op;
            cap_off <= req_addr[1:0];
        end
    end

    // Writeback register and FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= MEM_IDLE;
            mem_wb_o     <= create_nop_buffer();
            misaligned_o <= 1'b0;
        end else begin
            mem_wb_o     <= wb_next;
            misaligned_o <= trap && (state == MEM_IDLE);
            case (state)
                MEM_IDLE:      if (accept && is_load(in_op)) state <= MEM_WAIT_RESP;
                MEM_WAIT_RESP: if (dmem_resp_valid_i)        state <= MEM_IDLE;
                default:                                     state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv32_mem_stage.md
RV32_MEM_STAGE -- requirements
Module: rv32_mem_stage

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1, meaning 1 = trap misaligned accesses and 0 = issue them with the address forced to natural alignment.
REQ-002 SHALL use one clock and an asynchronous, active-low reset; the ports are:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- exec_mem_i  in  exec_mem_buffer_t  instruction from exec; upstream holds it while stall_o=1
- stall_o  out  1  combinational; upstream must hold exec_mem_i
- dmem_req_o  out  memory_request_t  data-memory request
- dmem_req_valid_o  out  1  request valid
- dmem_req_ready_i  in  1  memory accepts request this cycle
- dmem_resp_valid_i  in  1  load data valid
- dmem_resp_data_i  in  32  aligned load word
- mem_wb_o  out  mem_wb_buffer_t  registered writeback buffer
- misaligned_o  out  1  registered one-cycle misalignment flag

Function
REQ-003 SHALL implement a two-state FSM, IDLE and WAIT_RESP, with the following transitions:
- IDLE -> WAIT_RESP on load acceptance (dmem_req_valid_o & dmem_req_ready_i, load op)
- WAIT_RESP -> IDLE on dmem_resp_valid_i
REQ-004 SHALL classify input ops: "mem" = mem_op != MEM_NOP && !decoded_instr.invalid; "misaligned" = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-005 SHALL, for a non-mem input in IDLE, register exec_mem_i into mem_wb_o unchanged; latency 1 cycle, stall_o=0.
REQ-006 SHALL, in IDLE with a mem op that is not trapped, drive the request combinationally:
- dmem_req_valid_o=1
- addr = mem_addr, with low bits cleared when ALIGN_CHECK=0
- op = mem_op
REQ-007 SHALL drive store data from wb_result with lane replication: SB -> byte x4, SH -> halfword x2, SW -> word.
REQ-008 SHALL, while a request is not yet accepted, hold stall_o=1 and hold the request stable.
REQ-009 SHALL complete a store on acceptance: stall_o=0 that cycle, and the store is registered into mem_wb_o at the edge.
REQ-010 SHALL, on load acceptance, assert stall_o=1 and capture mem_op and addr[1:0] internally.
REQ-011 SHALL drive dmem_req_valid_o=0 in WAIT_RESP.
REQ-012 SHALL, in WAIT_RESP, hold stall_o=1 until dmem_resp_valid_i.
REQ-013 SHALL, in the WAIT_RESP response cycle, drop stall_o to 0 and register the instruction into mem_wb_o with wb_result = extracted data. Extraction:
- LB/LBU: byte at addr[1:0]
- LH/LHU: halfword at addr[1]
- LW: full word
- sign-extended for LB/LH, zero-extended for LBU/LHU
REQ-014 SHALL load a NOP bubble into mem_wb_o at every edge where stall_o=1. Bubble contents: instr=RV_NOP, pc=0, decoded_instr=create_nop_ctrl(), mem_addr=0, wb_result=0.
REQ-015 SHALL, when ALIGN_CHECK=1 and the op is misaligned, handle it as follows:
- issue no request
- pass the instruction through in 1 cycle with decoded_instr.invalid=1 and register_wb=0
- set misaligned_o=1 for exactly that registered cycle
REQ-016 SHALL ignore dmem_resp_valid_i while in IDLE.
REQ-017 SHALL, for an input with decoded_instr.invalid=1, issue no request and pass it through like a non-mem op.
REQ-018 SHALL keep misaligned_o=0 in all cycles other than REQ-015.
REQ-019 SHALL give back-to-back accepted loads 2 cycles each: issue+accept, then response.

Reset
REQ-020 SHALL, on resetn=0 (asynchronous, any state), force:
- state = IDLE
- mem_wb_o = NOP bubble
- misaligned_o = 0
- dmem_req_valid_o = 0 while in reset
REQ-021 SHALL drop any response outstanding at reset; a late dmem_resp_valid_i after reset is ignored per REQ-016.

Structure
REQ-022 SHALL add to package rv32_types: the enum mem_stage_state_t {MEM_IDLE, MEM_WAIT_RESP}, and the functions is_misaligned(mem_op_t, logic[1:0]) and create_nop_buffer() returning exec_mem_buffer_t.
REQ-023 SHALL place load extraction/extension in one combinational sub-module, rv32_load_align (inputs: word, mem_op_t, addr[1:0]; output: rv32_word).

Verification
REQ-024 SHALL cover ALU pass-through: OPCODE_INTEGER_REG input with wb_result=0x1234 -> mem_wb_o.wb_result=0x1234 next cycle, stall_o=0, no request.
REQ-025 SHALL cover a sign-extended load: LB at addr 0x1003, ready=1, response 0x80FF_0000 one cycle later -> wb_result=0xFFFFFF80, one bubble emitted, stall_o high exactly 1 cycle.
REQ-026 SHALL cover a store with backpressure: SB addr 0x2001, wb_result=0xAB, ready low 3 cycles -> request held with data 0xABABABAB for 4 cycles, stall_o=1 for 3, 3 bubbles.
REQ-027 SHALL cover a misaligned access: LW at 0x3002 with ALIGN_CHECK=1 -> no request, invalid=1, register_wb=0, misaligned_o=1 for one cycle.
REQ-028 SHALL cover reset during WAIT_RESP: LHU accepted, then resetn=0 -> IDLE with a NOP bubble; a response pulse after release leaves mem_wb_o unchanged.
REQ-029 SHALL cover zero extension: LHU at 0x4002, response 0xBEEF_0000 -> wb_result=0x0000BEEF.
